// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared CPU fetch types
// and the TLB-less kseg address map.
package ifu_fetch_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] phys_t;

  typedef struct packed {
    virt_t       pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam virt_t BOOT_VEC_DEF = 32'hbfc00000;

  // kseg0/kseg1 strip the top 3 bits;
  // everything else maps 1:1.
  function automatic phys_t kseg_translate(
    input virt_t va
  );
    return (va[31:30] == 2'b10) ?
      {3'b000, va[28:0]} : va;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of fetch_entry_t.
// push/pop/flush in; rdata/full/empty/count out.
import ifu_fetch_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     sync_rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop_ok;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_ok = pop & ~empty;
  // Head reads as zero when empty.
  assign rdata  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push)
                     - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch PC, kseg translate, in-order
// icache reads, PC queue, instruction FIFO.
import ifu_fetch_pkg::*;

module ifu_fetch #(
  parameter virt_t BOOT_VEC   = BOOT_VEC_DEF,
  parameter int    LINE_WIDTH = 256,
  parameter int    FIFO_DEPTH = 4,
  parameter int    MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ibus_read,
  output logic [31:0] ibus_vaddr,
  output logic [31:0] ibus_paddr,
  output logic [31:0] ibus_paddr_plus1,
  output logic        ibus_inv,
  output logic [31:0] ibus_inv_addr,
  input  logic        ibus_ready,
  input  logic        ibus_valid,
  input  logic [31:0] ibus_rddata,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  input  logic        inst_ready
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int QW =
    (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  virt_t          fetch_pc;
  logic [OW-1:0]  outst;
  logic [OW-1:0]  drop_cnt;
  virt_t          pcq [MAX_OUTST];
  logic [QW-1:0]  q_wr;
  logic [QW-1:0]  q_rd;

  logic           acc;
  logic           f_push;
  logic           f_pop;
  logic           f_full;
  logic           f_empty;
  logic [CW-1:0]  f_cnt;
  fetch_entry_t   f_wdata;
  fetch_entry_t   f_head;

  function automatic logic [QW-1:0] qnext(
    input logic [QW-1:0] p
  );
    return (int'(p) == MAX_OUTST - 1) ?
      '0 : p + QW'(1);
  endfunction

  // Dropped-but-pending reads still count
  // against FIFO space; conservative is fine.
  assign ibus_read = !sync_rst && !redirect
    && (int'(outst) < MAX_OUTST)
    && (int'(f_cnt) + int'(outst) < FIFO_DEPTH);

  assign acc = ibus_read & ibus_ready;

  assign ibus_vaddr       = fetch_pc;
  assign ibus_paddr       = kseg_translate(fetch_pc);
  assign ibus_paddr_plus1 =
    ibus_paddr + 32'(LINE_WIDTH / 8);
  assign ibus_inv         = 1'b0;
  assign ibus_inv_addr    = '0;

  assign f_push  = ibus_valid && !redirect
                && (drop_cnt == '0);
  assign f_pop   = inst_ready & inst_valid;
  assign f_wdata = '{pc: pcq[q_rd], inst: ibus_rddata};

  always_ff @(posedge clk) begin
    if (acc)
      pcq[q_wr] <= fetch_pc;
  end

  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      fetch_pc <= BOOT_VEC;
      outst    <= '0;
      drop_cnt <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
    end else begin
      if (redirect)
        fetch_pc <= redirect_pc & ~32'h3;
      else if (acc)
        fetch_pc <= fetch_pc + 32'd4;
      if (acc)
        q_wr <= qnext(q_wr);
      if (ibus_valid)
        q_rd <= qnext(q_rd);
      outst <= outst + OW'(acc)
                     - OW'(ibus_valid);
      // Everything still in flight belongs to
      // the old stream; this cycle's response
      // is discarded directly.
      if (redirect)
        drop_cnt <= outst - OW'(ibus_valid);
      else if (ibus_valid && drop_cnt != '0)
        drop_cnt <= drop_cnt - OW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .sync_rst (sync_rst),
    .flush    (redirect),
    .push     (f_push),
    .wdata    (f_wdata),
    .pop      (f_pop),
    .rdata    (f_head),
    .full     (f_full),
    .empty    (f_empty),
    .count    (f_cnt)
  );

  assign inst_valid = !f_empty;
  assign inst_pc    = f_head.pc;
  assign inst       = f_head.inst;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (sync_rst)
    !(f_push && f_full && !f_pop)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: random icache/decode/redirect
// stimulus against a queue-based fetch model.
module tb_ifu_fetch;

  localparam logic [31:0] BOOT = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        sync_rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ibus_read;
  logic [31:0] ibus_vaddr;
  logic [31:0] ibus_paddr;
  logic [31:0] ibus_paddr_plus1;
  logic        ibus_inv;
  logic [31:0] ibus_inv_addr;
  logic        ibus_ready = 1'b0;
  logic        ibus_valid = 1'b0;
  logic [31:0] ibus_rddata = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        inst_ready = 1'b0;

  ifu_fetch dut (
    .clk              (clk),
    .sync_rst         (sync_rst),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .ibus_read        (ibus_read),
    .ibus_vaddr       (ibus_vaddr),
    .ibus_paddr       (ibus_paddr),
    .ibus_paddr_plus1 (ibus_paddr_plus1),
    .ibus_inv         (ibus_inv),
    .ibus_inv_addr    (ibus_inv_addr),
    .ibus_ready       (ibus_ready),
    .ibus_valid       (ibus_valid),
    .ibus_rddata      (ibus_rddata),
    .inst_valid       (inst_valid),
    .inst_pc          (inst_pc),
    .inst             (inst),
    .inst_ready       (inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d;
  } ent_t;

  req_t        cq[$];
  ent_t        mf[$];
  logic [31:0] m_pc = BOOT;
  int          m_out = 0;
  int          m_drop = 0;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  t_rst = 1'b1;
  bit  t_redir = 1'b0;
  bit  t_rdy = 1'b1;
  bit  t_irdy = 1'b1;
  logic [31:0] t_rpc = '0;
  int  lat_max = 0;
  bit  arm = 1'b0;
  logic [31:0] arm_pc = '0;
  bit  exp_read;
  bit  rsp_v;

  function automatic logic [31:0] xlate(
    input logic [31:0] va
  );
    if (va >= 32'ha0000000 && va < 32'hc0000000)
      return va - 32'ha0000000;
    if (va >= 32'h80000000 && va < 32'ha0000000)
      return va - 32'h80000000;
    return va;
  endfunction

  function automatic logic [31:0] word(
    input logic [31:0] pc
  );
    return (pc * 32'h9e3779b1) ^ 32'h5ca1ab1e;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    sync_rst    = t_rst;
    ibus_ready  = t_rdy;
    inst_ready  = t_irdy;
    redirect_pc = t_rpc;
    if (t_rst) begin
      m_pc = BOOT;
      m_out = 0;
      m_drop = 0;
      mf.delete();
      cq.delete();
      rsp_v = 1'($urandom_range(0, 1));
    end else begin
      rsp_v = cq.size() > 0 && cq[0].due <= cyc;
    end
    ibus_valid  = rsp_v;
    ibus_rddata = (cq.size() > 0) ? cq[0].d
                                  : $urandom;
    redirect = t_redir && !t_rst;
    if (arm && !t_rst && rsp_v && m_out == 2
        && mf.size() > 0 && t_irdy) begin
      redirect    = 1'b1;
      redirect_pc = arm_pc;
      arm         = 1'b0;
    end
    exp_read = !t_rst && !redirect && m_out < 2
            && mf.size() + m_out < 4;
    #1;
    chk("ibus_read", 32'(ibus_read), 32'(exp_read));
    chk("ibus_vaddr", ibus_vaddr, m_pc);
    chk("ibus_paddr", ibus_paddr, xlate(m_pc));
    chk("ibus_paddr_plus1", ibus_paddr_plus1,
        xlate(m_pc) + 32'd32);
    chk("ibus_inv", 32'(ibus_inv), 32'd0);
    chk("ibus_inv_addr", ibus_inv_addr, 32'd0);
    chk("inst_valid", 32'(inst_valid),
        32'(mf.size() > 0));
    if (mf.size() > 0) begin
      chk("inst_pc", inst_pc, mf[0].pc);
      chk("inst", inst, mf[0].d);
    end
    if (t_rst) begin
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_inst", inst, 32'd0);
    end
  endtask

  task automatic cyc_end();
    bit   acc;
    bit   got;
    ent_t h;
    acc = exp_read && ibus_ready;
    got = 1'b0;
    if (!sync_rst) begin
      if (rsp_v) begin
        h = '{cq[0].pc, cq[0].d};
        cq.pop_front();
        if (!redirect) begin
          if (m_drop == 0) got = 1'b1;
          else m_drop--;
        end
      end
      if (!redirect && inst_ready && mf.size() > 0)
        void'(mf.pop_front());
      if (got)
        mf.push_back(h);
      if (redirect) begin
        mf.delete();
        m_drop = m_out - int'(rsp_v);
        m_pc   = redirect_pc & ~32'h3;
      end else if (acc) begin
        cq.push_back('{m_pc, word(m_pc),
          cyc + 1 + $urandom_range(0, lat_max)});
        m_pc = m_pc + 32'd4;
      end
      m_out = m_out + int'(acc) - int'(rsp_v);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return {16'h8000, r[15:0]};
      1:       return {16'hbfc0, r[15:0]};
      default: return {16'h0040, r[15:0]};
    endcase
  endfunction

  initial begin
    int pops;
    int rst_hold;
    logic [31:0] hold_va;

    // reset, then decode stalled for 10 cycles
    t_rst = 1'b1; t_irdy = 1'b0; t_rdy = 1'b1;
    cyc_begin();
    chk("lit_rst_read", 32'(ibus_read), 32'd0);
    chk("lit_rst_valid", 32'(inst_valid), 32'd0);
    chk("lit_rst_vaddr", ibus_vaddr, BOOT);
    cyc_end();
    step();
    t_rst = 1'b0;
    cyc_begin();
    chk("lit_first_read", 32'(ibus_read), 32'd1);
    chk("lit_first_vaddr", ibus_vaddr, 32'hbfc00000);
    chk("lit_first_paddr", ibus_paddr, 32'h1fc00000);
    chk("lit_first_plus1", ibus_paddr_plus1,
        32'h1fc00020);
    cyc_end();
    for (int i = 0; i < 9; i++) step();
    cyc_begin();
    chk("lit_stall_read", 32'(ibus_read), 32'd0);
    chk("lit_stall_head", inst_pc, 32'hbfc00000);
    cyc_end();
    t_irdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc_begin();
      chk("lit_drain_pc", inst_pc,
          32'hbfc00000 + 32'(4 * i));
      cyc_end();
    end

    // always-hit stream, one instruction per cycle
    for (int i = 0; i < 10; i++) step();
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      cyc_begin();
      if (inst_valid) pops++;
      cyc_end();
    end
    chk("lit_throughput", 32'(pops), 32'd10);

    // icache miss: ready low for 8 cycles
    t_rdy = 1'b0;
    cyc_begin();
    hold_va = ibus_vaddr;
    cyc_end();
    for (int i = 0; i < 7; i++) step();
    cyc_begin();
    chk("lit_miss_hold", ibus_vaddr, hold_va);
    cyc_end();
    t_rdy = 1'b1;

    // redirect with two reads outstanding
    lat_max = 3;
    for (int i = 0; i < 50 && m_out != 2; i++)
      step();
    chk("outst2_reached", 32'(m_out), 32'd2);
    t_redir = 1'b1; t_rpc = 32'h80001000;
    step();
    t_redir = 1'b0;
    cyc_begin();
    chk("lit_redir_vaddr", ibus_vaddr, 32'h80001000);
    chk("lit_redir_paddr", ibus_paddr, 32'h00001000);
    chk("lit_redir_empty", 32'(inst_valid), 32'd0);
    cyc_end();
    for (int i = 0; i < 10; i++) step();

    // redirect together with a response and a pop
    lat_max = 1;
    arm = 1'b1; arm_pc = 32'h00400002;
    for (int i = 0; i < 400 && arm; i++) begin
      t_irdy = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("armed_redirect_hit", 32'(arm), 32'd0);
    arm = 1'b0;
    t_irdy = 1'b1;
    cyc_begin();
    chk("lit_kuseg_vaddr", ibus_vaddr, 32'h00400000);
    chk("lit_kuseg_paddr", ibus_paddr, 32'h00400000);
    cyc_end();
    for (int i = 0; i < 8; i++) step();

    // reset mid-stream
    t_irdy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    t_rst = 1'b1;
    cyc_begin();
    chk("lit_mid_rst_read", 32'(ibus_read), 32'd0);
    chk("lit_mid_rst_valid", 32'(inst_valid), 32'd0);
    cyc_end();
    step();
    t_rst = 1'b0; t_irdy = 1'b1;
    cyc_begin();
    chk("lit_restart_vaddr", ibus_vaddr, BOOT);
    cyc_end();

    // randomized traffic
    lat_max = 3;
    rst_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      t_rdy   = ($urandom_range(0, 9) < 8);
      t_irdy  = ($urandom_range(0, 9) < 7);
      t_redir = ($urandom_range(0, 99) < 3);
      t_rpc   = rand_pc();
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 199) == 0)
        rst_hold = $urandom_range(1, 2);
      t_rst = (rst_hold > 0);
      step();
    end
    t_rst = 1'b0; t_redir = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
